// File: rtl/sequential_divider_if.sv
// Command/operand/result bundle for the sequential divider.
// The master side issues commands; the slave side is the divider.
interface sequential_divider_if #(
    parameter int p_data_width = 7
);
    logic [2*p_data_width-1:0] i_w_dividend;
    logic [p_data_width-1:0]   i_w_divisor;
    logic                      i_w_write;
    logic                      i_w_divide;
    logic                      i_w_display;
    logic [p_data_width-1:0]   o_w_quotient;
    logic [p_data_width-1:0]   o_w_remainder;
    logic                      o_w_busy;
    logic                      o_w_done;
    logic                      o_w_error;

    modport master (
        output i_w_dividend, i_w_divisor, i_w_write, i_w_divide, i_w_display,
        input  o_w_quotient, o_w_remainder, o_w_busy, o_w_done, o_w_error
    );

    modport slave (
        input  i_w_dividend, i_w_divisor, i_w_write, i_w_divide, i_w_display,
        output o_w_quotient, o_w_remainder, o_w_busy, o_w_done, o_w_error
    );
endinterface

// File: rtl/sequential_divider.sv
// Restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Results are gated onto the outputs only while display is requested in DONE.
module sequential_divider #(
    parameter int p_data_width = 7
) (
    input logic                i_w_clk,
    input logic                i_w_reset,
    sequential_divider_if.slave bus
);
    localparam int W  = p_data_width;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] c_iterations = CW'(W);

    typedef enum logic [1:0] {
        IDLE,
        LOADED,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    logic [2*W-1:0]  dividend_q;
    logic [W-1:0]    divisor_q;
    logic [W-1:0]    rem_q;
    logic [W-1:0]    quo_q;
    logic [CW-1:0]   count_q;
    logic            error_q;

    logic [W:0]      trial;
    logic            trial_ok;

    // NOTE: always_comb assigns every output first so no path leaves a latch.
    always_comb begin
        trial    = '0;
        trial    = {rem_q, quo_q[W-1]} - {1'b0, divisor_q};
        trial_ok = ~trial[W];
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_w_clk) begin
        if (!i_w_reset) begin
            state      <= IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            count_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_w_write) begin
                        dividend_q <= bus.i_w_dividend;
                        divisor_q  <= bus.i_w_divisor;
                        state      <= LOADED;
                    end
                end

                LOADED, DONE: begin
                    if (bus.i_w_write) begin
                        dividend_q <= bus.i_w_dividend;
                        divisor_q  <= bus.i_w_divisor;
                        error_q    <= 1'b0;
                        state      <= LOADED;
                    end else if (bus.i_w_divide) begin
                        // A high half >= divisor means the quotient cannot fit in W bits.
                        if (divisor_q == '0 || dividend_q[2*W-1:W] >= divisor_q) begin
                            rem_q   <= '0;
                            quo_q   <= '0;
                            error_q <= 1'b1;
                            state   <= DONE;
                        end else begin
                            rem_q   <= dividend_q[2*W-1:W];
                            quo_q   <= dividend_q[W-1:0];
                            count_q <= c_iterations;
                            error_q <= 1'b0;
                            state   <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    if (trial_ok) begin
                        rem_q <= trial[W-1:0];
                        quo_q <= {quo_q[W-2:0], 1'b1};
                    end else begin
                        rem_q <= {rem_q[W-2:0], quo_q[W-1]};
                        quo_q <= {quo_q[W-2:0], 1'b0};
                    end
                    count_q <= count_q - 1'b1;
                    if (count_q == CW'(1)) begin
                        state <= DONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_w_busy      = (state == BUSY);
    assign bus.o_w_done      = (state == DONE);
    assign bus.o_w_error     = (state == DONE) && error_q;
    assign bus.o_w_quotient  = (state == DONE && bus.i_w_display) ? quo_q : '0;
    assign bus.o_w_remainder = (state == DONE && bus.i_w_display) ? rem_q : '0;
endmodule

// File: tb/tb_sequential_divider.sv
// Randomized and directed bench for sequential_divider, checked against
// plain integer division of the last written operands.
module tb_sequential_divider;
    localparam int W    = 7;
    localparam int MAXQ = (1 << W) - 1;

    logic i_w_clk;
    logic i_w_reset;

    sequential_divider_if #(.p_data_width(W)) bus ();

    sequential_divider #(.p_data_width(W)) dut (
        .i_w_clk   (i_w_clk),
        .i_w_reset (i_w_reset),
        .bus       (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int m_dd     = 0;
    int m_dv     = 0;

    initial i_w_clk = 1'b0;
    always #5 i_w_clk = ~i_w_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_w_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        bus.i_w_display = 1'b1;
        #1;
        check({tag, "_busy"}, int'(bus.o_w_busy), 0);
        check({tag, "_done"}, int'(bus.o_w_done), 0);
        check({tag, "_err"},  int'(bus.o_w_error), 0);
        check({tag, "_quo"},  int'(bus.o_w_quotient), 0);
        check({tag, "_rem"},  int'(bus.o_w_remainder), 0);
        bus.i_w_display = 1'b0;
    endtask

    task automatic write_ops(input int dd, input int dv);
        bus.i_w_dividend = (2*W)'(dd);
        bus.i_w_divisor  = W'(dv);
        bus.i_w_write    = 1'b1;
        step();
        bus.i_w_write = 1'b0;
        m_dd = dd;
        m_dv = dv;
        check("write_done", int'(bus.o_w_done), 0);
        check("write_busy", int'(bus.o_w_busy), 0);
    endtask

    // Pulses divide, waits for done, and checks latency, flags and gated results.
    // With inject set, a 50/5 write is presented during BUSY and must be ignored.
    task automatic run_div(input bit inject);
        bit exp_err;
        int exp_q;
        int exp_r;
        int lat;
        exp_err = (m_dv == 0);
        exp_q   = 0;
        exp_r   = 0;
        if (!exp_err) begin
            exp_q = m_dd / m_dv;
            exp_r = m_dd % m_dv;
            if (exp_q > MAXQ) exp_err = 1'b1;
        end
        if (exp_err) begin
            exp_q = 0;
            exp_r = 0;
        end

        bus.i_w_divide = 1'b1;
        step();
        bus.i_w_divide = 1'b0;
        lat = 0;
        if (!exp_err) begin
            check("busy_start", int'(bus.o_w_busy), 1);
            bus.i_w_display = 1'b1;
            #1;
            check("busy_disp_quo", int'(bus.o_w_quotient), 0);
            check("busy_disp_rem", int'(bus.o_w_remainder), 0);
            bus.i_w_display = 1'b0;
            if (inject) begin
                bus.i_w_dividend = (2*W)'(50);
                bus.i_w_divisor  = W'(5);
                bus.i_w_write    = 1'b1;
            end
        end
        while (!bus.o_w_done && lat < 4 * W) begin
            step();
            bus.i_w_write = 1'b0;
            lat++;
        end
        check("latency", lat, exp_err ? 0 : W);
        check("done",    int'(bus.o_w_done), 1);
        check("busy_end", int'(bus.o_w_busy), 0);
        check("error",   int'(bus.o_w_error), int'(exp_err));
        bus.i_w_display = 1'b1;
        #1;
        check("quotient",  int'(bus.o_w_quotient), exp_q);
        check("remainder", int'(bus.o_w_remainder), exp_r);
        bus.i_w_display = 1'b0;
        #1;
        check("hidden_quo", int'(bus.o_w_quotient), 0);
        check("hidden_rem", int'(bus.o_w_remainder), 0);
    endtask

    initial begin
        int mode, q, r, dv, dd;
        bus.i_w_dividend = '0;
        bus.i_w_divisor  = '0;
        bus.i_w_write    = 1'b0;
        bus.i_w_divide   = 1'b0;
        bus.i_w_display  = 1'b0;
        i_w_reset        = 1'b0;
        step();
        step();
        check_all_zero("reset");
        i_w_reset = 1'b1;

        // Divide with no operands in IDLE is ignored.
        bus.i_w_divide = 1'b1;
        step();
        bus.i_w_divide = 1'b0;
        check("idle_div_busy", int'(bus.o_w_busy), 0);
        check("idle_div_done", int'(bus.o_w_done), 0);

        write_ops(100, 7);
        run_div(1'b0);
        write_ops(16129, 127);
        run_div(1'b0);
        write_ops(16128, 127);
        run_div(1'b0);
        write_ops(16256, 127);
        run_div(1'b0);
        write_ops(5, 0);
        run_div(1'b0);

        // Write during BUSY is ignored; write+divide in DONE only reloads.
        write_ops(100, 7);
        run_div(1'b1);
        bus.i_w_dividend = (2*W)'(50);
        bus.i_w_divisor  = W'(5);
        bus.i_w_write    = 1'b1;
        bus.i_w_divide   = 1'b1;
        step();
        bus.i_w_write  = 1'b0;
        bus.i_w_divide = 1'b0;
        m_dd = 50;
        m_dv = 5;
        check("prio_done", int'(bus.o_w_done), 0);
        check("prio_busy", int'(bus.o_w_busy), 0);
        check("prio_err",  int'(bus.o_w_error), 0);
        run_div(1'b0);

        // Reset on the 3rd iteration edge aborts the operation.
        write_ops(100, 7);
        bus.i_w_divide = 1'b1;
        step();
        bus.i_w_divide = 1'b0;
        step();
        step();
        i_w_reset = 1'b0;
        step();
        check_all_zero("abort");
        i_w_reset = 1'b1;
        bus.i_w_divide = 1'b1;
        step();
        bus.i_w_divide = 1'b0;
        check("abort_div_busy", int'(bus.o_w_busy), 0);
        step();
        check("abort_div_done", int'(bus.o_w_done), 0);

        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 4));
            if (mode == 0) begin
                dv = 0;
                dd = int'($urandom_range(0, 16383));
            end else if (mode == 1) begin
                dv = int'($urandom_range(1, 127));
                dd = int'($urandom_range(16383, dv * 128));
            end else begin
                dv = int'($urandom_range(1, 127));
                q  = int'($urandom_range(0, 127));
                r  = int'($urandom_range(0, dv - 1));
                dd = q * dv + r;
            end
            write_ops(dd, dv);
            run_div(1'b0);
            if (i % 5 == 0) run_div(1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
